spectrum_draw_scheduler: RTL and testbench

Frame-level sequencer for the per-column spectrum bar writer. On each frame sync it reads bar heights from the bar buffer and drives the writer through one full frame. A frame is the Lch screen (COLUMNS bars), an LR switch, then the Rch screen (COLUMNS bars). It handles the Start/End handshake with the writer, clamps bar heights, detects overruns, and aborts with a fault if the writer stalls.

---
 rtl/spectrum_draw_scheduler.sv | 132 +++++++++++++
 tb/tb_spectrum_draw_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_draw_scheduler.sv
// Purpose: frame sequencer driving the spectrum bar writer; L screen, LR switch, R screen per FrameSync.
// Latency: FrameSync -> WrLRChange +1 cycle, WrStart +4 cycles; 4 cycles overhead per bar plus writer time.
// Backpressure: waits on writer WrBusy/WrEnd per bar; FrameSync while busy is dropped and flagged as Overrun.
//
// Ports:
//   Clock, Reset          system clock, asynchronous active-high reset
//   FrameSync             one-cycle redraw request
//   BarAddr, BarCh        bar buffer read address / channel (held outside FETCH)
//   BarData               bar buffer read data, valid one cycle after address
//   WrStart, WrBar        writer start pulse and clamped bar height
//   WrLRChange            writer channel toggle pulse
//   WrBusy, WrEnd         writer status levels
//   Busy, FrameDone       sequencer activity level and frame completion pulse
//   Overrun, Fault        dropped-request pulse and writer-stall pulse
`timescale 1ns/1ps
module spectrum_draw_scheduler #(
    parameter int COLUMNS = 400,
    parameter int BAR_MAX = 96,
    parameter int TIMEOUT = 255
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       FrameSync,
    output logic [8:0] BarAddr,
    output logic       BarCh,
    input  logic [6:0] BarData,
    output logic       WrStart,
    output logic [6:0] WrBar,
    output logic       WrLRChange,
    input  logic       WrBusy,
    input  logic       WrEnd,
    output logic       Busy,
    output logic       FrameDone,
    output logic       Overrun,
    output logic       Fault
);

    typedef enum logic [2:0] {
        IDLE, SWITCH, FETCH, LATCH, START, WAIT, DONE
    } state_t;

    localparam logic [8:0] LAST_COL = 9'(COLUMNS - 1);
    localparam logic [6:0] BAR_LIM  = 7'(BAR_MAX);
    localparam logic [7:0] WDOG_LIM = 8'(TIMEOUT);

    state_t     state, state_n;
    logic [8:0] col, col_n;
    logic       ch, ch_n;
    logic [7:0] wdog, wdog_n;
    logic       fault_c;

    always_comb begin
        state_n = state;
        col_n   = col;
        ch_n    = ch;
        wdog_n  = wdog;
        fault_c = 1'b0;
        case (state)
            IDLE: begin
                if (FrameSync) begin
                    col_n   = '0;
                    ch_n    = 1'b0;
                    state_n = SWITCH;
                end
            end
            SWITCH: state_n = FETCH;
            FETCH:  state_n = LATCH;
            LATCH:  state_n = START;
            START: begin
                wdog_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // wdog is 0 only in the first WAIT cycle, where WrEnd may still be
                // the stale level from the previous bar, so completion is ignored there.
                if ((wdog != 8'd0) && !WrBusy && WrEnd) begin
                    if (col != LAST_COL) begin
                        col_n   = col + 9'd1;
                        state_n = FETCH;
                    end else if (!ch) begin
                        ch_n    = 1'b1;
                        col_n   = '0;
                        state_n = SWITCH;
                    end else begin
                        state_n = DONE;
                    end
                end else if (wdog == WDOG_LIM) begin
                    fault_c = 1'b1;
                    state_n = IDLE;
                end else begin
                    wdog_n = wdog + 8'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            col     <= '0;
            ch      <= 1'b0;
            wdog    <= '0;
            BarAddr <= '0;
            BarCh   <= 1'b0;
            WrBar   <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            ch    <= ch_n;
            wdog  <= wdog_n;
            // Address is loaded on entry so it is presented throughout FETCH;
            // the buffer answers during LATCH, which captures it.
            if (state_n == FETCH) begin
                BarAddr <= col_n;
                BarCh   <= ch_n;
            end
            if (state == LATCH) begin
                WrBar <= (BarData > BAR_LIM) ? BAR_LIM : BarData;
            end
        end
    end

    assign Busy       = (state != IDLE);
    assign WrStart    = (state == START);
    assign WrLRChange = (state == SWITCH);
    assign FrameDone  = (state == DONE);
    assign Overrun    = FrameSync && (state != IDLE);
    assign Fault      = fault_c;

endmodule

// File: tb/tb_spectrum_draw_scheduler.sv
`timescale 1ns/1ps
module tb_spectrum_draw_scheduler;

    localparam int COLUMNS = 400;
    localparam int BAR_MAX = 96;
    localparam int TIMEOUT = 255;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       FrameSync;
    logic [8:0] BarAddr;
    logic       BarCh;
    logic [6:0] BarData;
    logic       WrStart;
    logic [6:0] WrBar;
    logic       WrLRChange;
    logic       WrBusy;
    logic       WrEnd;
    logic       Busy;
    logic       FrameDone;
    logic       Overrun;
    logic       Fault;

    spectrum_draw_scheduler #(
        .COLUMNS(COLUMNS), .BAR_MAX(BAR_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .FrameSync(FrameSync),
        .BarAddr(BarAddr), .BarCh(BarCh), .BarData(BarData),
        .WrStart(WrStart), .WrBar(WrBar), .WrLRChange(WrLRChange),
        .WrBusy(WrBusy), .WrEnd(WrEnd), .Busy(Busy),
        .FrameDone(FrameDone), .Overrun(Overrun), .Fault(Fault)
    );

    initial forever #5 Clock = ~Clock;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- writer model ----------------
    int rise_dly = 1;     // cycles after WrStart before the writer reacts
    int busy_len = 10;
    int hang_at  = -1;    // bar index (within frame) on which the writer stalls
    int wr_idx   = 0;
    bit stale    = 0;     // keep WrEnd high throughout
    int phase    = 0;
    int cnt      = 0;
    bit hang_cur = 0;

    initial begin
        WrBusy = 1'b0;
        WrEnd  = 1'b0;
        forever begin
            @(posedge Clock);
            #2;
            if (WrStart) begin
                phase    = rise_dly;
                hang_cur = (wr_idx == hang_at);
                wr_idx++;
            end else if (phase > 0) begin
                phase--;
                if (phase == 0) begin
                    if (hang_cur) begin
                        WrBusy = 1'b0;
                        WrEnd  = 1'b0;
                    end else begin
                        WrBusy = 1'b1;
                        WrEnd  = stale ? 1'b1 : 1'b0;
                        cnt    = busy_len;
                    end
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    WrBusy = 1'b0;
                    WrEnd  = 1'b1;
                end
            end
        end
    end

    // ---------------- bar buffer model (one cycle read latency) ----------------
    int         bar_mode = 0;
    logic [8:0] prev_addr = '0;
    logic [6:0] data_tbl[4] = '{7'd96, 7'd97, 7'd127, 7'd0};
    logic [6:0] clamp_exp[4] = '{7'd96, 7'd96, 7'd96, 7'd0};

    initial begin
        BarData = '0;
        forever begin
            @(negedge Clock);
            if (bar_mode == 0) BarData = 7'(prev_addr % 97);
            else               BarData = data_tbl[prev_addr[1:0]];
            prev_addr = BarAddr;
        end
    end

    // ---------------- output monitor ----------------
    int          cyc = 0;
    int          n_start = 0, n_lrc = 0, n_done = 0, n_ovr = 0, n_fault = 0, fault_cyc = 0;
    logic [16:0] rec_q[$];
    int          start_cyc[$];
    int          lrc_pos[$];

    initial forever begin
        @(negedge Clock);
        cyc++;
        if (WrStart) begin
            chk("start_while_busy", 32'(WrBusy), 32'd0);
            rec_q.push_back({BarCh, BarAddr, WrBar});
            start_cyc.push_back(cyc);
            n_start++;
        end
        if (WrLRChange) begin
            lrc_pos.push_back(n_start);
            n_lrc++;
        end
        if (FrameDone) n_done++;
        if (Overrun)   n_ovr++;
        if (Fault) begin
            n_fault++;
            fault_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && n_start < n; k++) tick();
        chk(tag, 32'(n_start >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int k = 0; k < budget && !FrameDone; k++) tick();
        chk(tag, 32'(FrameDone), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [16:0] e;
        int          c;
        int          h;
        int          fc;

        Reset     = 1'b1;
        FrameSync = 1'b0;
        repeat (3) tick();
        @(negedge Clock);
        chk("rst_busy",   32'(Busy),       32'd0);
        chk("rst_start",  32'(WrStart),    32'd0);
        chk("rst_lrc",    32'(WrLRChange), 32'd0);
        chk("rst_done",   32'(FrameDone),  32'd0);
        chk("rst_ovr",    32'(Overrun),    32'd0);
        chk("rst_fault",  32'(Fault),      32'd0);
        chk("rst_addr",   32'(BarAddr),    32'd0);
        chk("rst_ch",     32'(BarCh),      32'd0);
        chk("rst_wrbar",  32'(WrBar),      32'd0);
        tick();
        Reset = 1'b0;
        repeat (2) tick();

        // Reset in the middle of WAIT on column 37 of the R channel (bar 437).
        FrameSync = 1'b1;
        tick();
        FrameSync = 1'b0;
        wait_starts(438, 10000, "reach_col37_r");
        repeat (3) tick();
        #2;
        Reset = 1'b1;
        @(negedge Clock);
        chk("midrst_busy",  32'(Busy),    32'd0);
        chk("midrst_addr",  32'(BarAddr), 32'd0);
        chk("midrst_ch",    32'(BarCh),   32'd0);
        chk("midrst_wrbar", 32'(WrBar),   32'd0);
        tick();
        rec_q.delete(); start_cyc.delete(); lrc_pos.delete();
        n_start = 0; n_lrc = 0; n_done = 0; n_ovr = 0; n_fault = 0;
        tick();
        Reset = 1'b0;
        repeat (12) tick();
        chk("no_lrc_on_rst_exit", 32'(n_lrc), 32'd0);
        chk("idle_after_rst",     32'(Busy),  32'd0);

        // Frame A: normal writer (busy 10), BarData = col mod 97, overruns at bar 100 and at DONE.
        FrameSync = 1'b1;
        @(negedge Clock);
        chk("a_idle_busy", 32'(Busy),    32'd0);
        chk("a_idle_ovr",  32'(Overrun), 32'd0);
        tick();
        FrameSync = 1'b0;
        @(negedge Clock);
        chk("a_t1_lrc",  32'(WrLRChange), 32'd1);
        chk("a_t1_busy", 32'(Busy),       32'd1);
        tick();
        @(negedge Clock);
        chk("a_t2_addr", 32'(BarAddr),    32'd0);
        chk("a_t2_ch",   32'(BarCh),      32'd0);
        chk("a_t2_lrc",  32'(WrLRChange), 32'd0);
        tick();
        @(negedge Clock);
        chk("a_t3_start", 32'(WrStart), 32'd0);
        tick();
        @(negedge Clock);
        chk("a_t4_start", 32'(WrStart), 32'd1);

        wait_starts(101, 3000, "reach_bar100");
        FrameSync = 1'b1;
        @(negedge Clock);
        chk("ovr_bar100", 32'(Overrun), 32'd1);
        tick();
        FrameSync = 1'b0;
        wait_done(15000, "a_done_seen");
        chk("a_starts",   32'(n_start),    32'd800);
        chk("a_lrc",      32'(n_lrc),      32'd2);
        chk("a_lrc0_pos", 32'(lrc_pos[0]), 32'd0);
        chk("a_lrc1_pos", 32'(lrc_pos[1]), 32'd400);
        FrameSync = 1'b1;
        @(negedge Clock);
        chk("ovr_in_done", 32'(Overrun),   32'd1);
        chk("done_pulse",  32'(FrameDone), 32'd1);
        tick();
        // Frame B setup: stale-End writer, clamp data pattern. FrameSync held into the IDLE cycle.
        stale = 1; rise_dly = 2; busy_len = 5; bar_mode = 1;
        @(negedge Clock);
        chk("idle_after_done_ovr", 32'(Overrun), 32'd0);
        chk("idle_after_done",     32'(FrameDone), 32'd0);
        tick();
        FrameSync = 1'b0;
        chk("a_done_count", 32'(n_done), 32'd1);
        chk("a_ovr_count",  32'(n_ovr),  32'd2);
        @(negedge Clock);
        chk("b_accept_lrc", 32'(WrLRChange), 32'd1);

        wait_done(12000, "b_done_seen");
        repeat (2) tick();
        chk("b_done_count", 32'(n_done),  32'd2);
        chk("b_ovr_count",  32'(n_ovr),   32'd2);
        chk("total_starts", 32'(rec_q.size()), 32'd1600);
        chk("b_lrc",        32'(n_lrc),   32'd4);
        chk("b_lrc2_pos",   32'(lrc_pos[2]), 32'd800);
        chk("b_lrc3_pos",   32'(lrc_pos[3]), 32'd1200);
        chk("gap_a_bar",    32'(start_cyc[1] - start_cyc[0]),     32'd14);
        chk("gap_a_switch", 32'(start_cyc[400] - start_cyc[399]), 32'd15);
        chk("gap_b_stale",  32'(start_cyc[802] - start_cyc[801]), 32'd10);
        for (int i = 0; i < 1600; i++) begin
            if (i < 800) begin
                c = i % 400;
                h = i / 400;
                e = {1'(h), 9'(c), 7'(c % 97)};
            end else begin
                c = (i - 800) % 400;
                h = (i - 800) / 400;
                e = {1'(h), 9'(c), clamp_exp[c % 4]};
            end
            chk($sformatf("bar_rec_%0d", i), 32'(rec_q[i]), 32'(e));
        end

        // Frame C: writer never finishes bar 5 -> Fault, no FrameDone.
        stale = 0; rise_dly = 1; busy_len = 10; bar_mode = 0;
        wr_idx = 0; hang_at = 5;
        FrameSync = 1'b1;
        tick();
        FrameSync = 1'b0;
        for (int k = 0; k < 2000 && !Fault; k++) tick();
        chk("fault_seen", 32'(Fault), 32'd1);
        tick();
        @(negedge Clock);
        chk("fault_busy_low", 32'(Busy), 32'd0);
        fc = fault_cyc - start_cyc[$];
        chk("fault_latency", 32'(fc),      32'(TIMEOUT + 1));
        chk("c_starts",      32'(n_start), 32'd1606);
        chk("c_fault_count", 32'(n_fault), 32'd1);
        repeat (5) tick();
        chk("c_no_done",     32'(n_done),  32'd2);
        chk("c_stays_idle",  32'(Busy),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
